// File: rtl/io_port_bank.sv
// io_port_bank: NPORTS memory-mapped bidirectional ports of WIDTH bits on the 8-bit CPU bus.
// Each port has DDR, PORT, PIN (read = pin state, write = toggle PORT) and, when
// IOPORT_EDGE_IRQ_EN is defined, IER/IFR/EDGE registers with edge-detect interrupts.
// Without IOPORT_EDGE_IRQ_EN the interrupt registers read 0 and irq_n_o is tied high.
module io_port_bank #(
  parameter int unsigned NPORTS      = 2,
  parameter int unsigned WIDTH       = 8,
  parameter logic [15:0] BASE        = 16'h0000,
  parameter logic [7:0]  PORT_RST    = 8'h00,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_n,
  input  logic [15:0]             a_i,
  input  logic [7:0]              d_i,
  input  logic                    rwn_i,
  input  logic                    acc_i,
  output logic [7:0]              d_o,
  output logic                    hit_o,
  input  logic [NPORTS*WIDTH-1:0] pad_i,
  output logic [NPORTS*WIDTH-1:0] port_o,
  output logic [NPORTS*WIDTH-1:0] port_oe,
  output logic                    irq_n_o
);

  localparam int unsigned         Bits       = NPORTS * WIDTH;
  localparam logic [16:0]         BaseExt    = {1'b0, BASE};
  localparam logic [16:0]         Span       = 17'(8 * NPORTS);
  localparam logic [Bits-1:0]     PortRstAll = {NPORTS{PORT_RST[WIDTH-1:0]}};

  logic [16:0]     offset;
  logic            hit;
  logic [1:0]      sel;
  logic [2:0]      rsel;
  logic            we;
  logic [WIDTH-1:0] rd_w;

  logic [Bits-1:0] ddr_q, ddr_d;
  logic [Bits-1:0] port_q, port_d;
  logic [Bits-1:0] sync_q [SYNC_STAGES];
  logic [Bits-1:0] sync_in;

  // An address below BASE wraps to a huge offset, so one compare covers both bounds.
  assign offset  = {1'b0, a_i} - BaseExt;
  assign hit     = offset < Span;
  assign sel     = a_i[4:3];
  assign rsel    = a_i[2:0];
  assign we      = acc_i & ~rwn_i & hit;
  assign sync_in = sync_q[SYNC_STAGES-1];

  assign hit_o   = hit;
  assign port_o  = port_q;
  assign port_oe = ddr_q;

`ifdef IOPORT_EDGE_IRQ_EN
  localparam int unsigned ArmMax = SYNC_STAGES + 1;
  localparam int unsigned ArmW   = $clog2(ArmMax + 1);

  logic [Bits-1:0] ier_q, ier_d;
  logic [Bits-1:0] ifr_q, ifr_d;
  logic [Bits-1:0] edge_q, edge_d;
  logic [Bits-1:0] prev_q;
  logic [Bits-1:0] w1c;
  logic [Bits-1:0] det;
  logic [ArmW-1:0] arm_q, arm_d;
  logic            armed;
  logic            irq_n_q, irq_n_d;

  // Detection stays off until the reset zeros have flushed out of the synchronizer.
  assign armed   = arm_q == ArmW'(ArmMax);
  assign arm_d   = armed ? arm_q : arm_q + 1'b1;
  assign det     = armed ? ((sync_in & ~prev_q & edge_q) | (~sync_in & prev_q & ~edge_q)) : '0;
  assign irq_n_d = ~|(ifr_q & ier_q);
  assign irq_n_o = irq_n_q;
`else
  assign irq_n_o = 1'b1;
`endif

  // Register write decode; only the addressed port's slice changes.
  always_comb begin
    ddr_d  = ddr_q;
    port_d = port_q;
`ifdef IOPORT_EDGE_IRQ_EN
    ier_d  = ier_q;
    edge_d = edge_q;
    w1c    = '0;
`endif
    for (int unsigned p = 0; p < NPORTS; p++) begin
      if (we && sel == 2'(p)) begin
        case (rsel)
          3'd0: ddr_d[p*WIDTH +: WIDTH]  = d_i[WIDTH-1:0];
          3'd1: port_d[p*WIDTH +: WIDTH] = d_i[WIDTH-1:0];
          3'd2: port_d[p*WIDTH +: WIDTH] = port_q[p*WIDTH +: WIDTH] ^ d_i[WIDTH-1:0];
`ifdef IOPORT_EDGE_IRQ_EN
          3'd3: ier_d[p*WIDTH +: WIDTH]  = d_i[WIDTH-1:0];
          3'd4: w1c[p*WIDTH +: WIDTH]    = d_i[WIDTH-1:0];
          3'd5: edge_d[p*WIDTH +: WIDTH] = d_i[WIDTH-1:0];
`endif
          default: ;
        endcase
      end
    end
`ifdef IOPORT_EDGE_IRQ_EN
    // A new edge beats a simultaneous clear of the same bit.
    ifr_d = (ifr_q & ~w1c) | det;
`endif
  end

  // Read mux; unused data bits and non-hit accesses return zero.
  always_comb begin
    rd_w = '0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      if (sel == 2'(p)) begin
        case (rsel)
          3'd0: rd_w = ddr_q[p*WIDTH +: WIDTH];
          3'd1: rd_w = port_q[p*WIDTH +: WIDTH];
          3'd2: rd_w = (ddr_q[p*WIDTH +: WIDTH] & port_q[p*WIDTH +: WIDTH]) |
                       (~ddr_q[p*WIDTH +: WIDTH] & sync_in[p*WIDTH +: WIDTH]);
`ifdef IOPORT_EDGE_IRQ_EN
          3'd3: rd_w = ier_q[p*WIDTH +: WIDTH];
          3'd4: rd_w = ifr_q[p*WIDTH +: WIDTH];
          3'd5: rd_w = edge_q[p*WIDTH +: WIDTH];
`endif
          default: ;
        endcase
      end
    end
    d_o = '0;
    if (hit) d_o[WIDTH-1:0] = rd_w;
  end

  // Port registers and pad synchronizer; reset wins over a concurrent write.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      ddr_q  <= '0;
      port_q <= PortRstAll;
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      ddr_q     <= ddr_d;
      port_q    <= port_d;
      sync_q[0] <= pad_i;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

`ifdef IOPORT_EDGE_IRQ_EN
  // Interrupt registers, edge history, arm counter and registered irq output.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      ier_q   <= '0;
      ifr_q   <= '0;
      edge_q  <= '0;
      prev_q  <= '0;
      arm_q   <= '0;
      irq_n_q <= 1'b1;
    end else begin
      ier_q   <= ier_d;
      ifr_q   <= ifr_d;
      edge_q  <= edge_d;
      prev_q  <= sync_in;
      arm_q   <= arm_d;
      irq_n_q <= irq_n_d;
    end
  end
`endif

endmodule

// File: tb/tb_io_port_bank.sv
// Directed bench for io_port_bank: a vector table for register access and decode,
// plus hand sequences for output timing, edge interrupts, W1C races and reset arming.
module tb_io_port_bank;

  localparam logic [15:0] Base    = 16'h0020;
  localparam logic [7:0]  PortRst = 8'h81;
`ifdef IOPORT_EDGE_IRQ_EN
  localparam bit IrqEn = 1'b1;
`else
  localparam bit IrqEn = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a_i   = '0;
  logic [7:0]  d_i   = '0;
  logic        rwn_i = 1'b1;
  logic        acc_i = 1'b0;
  logic [7:0]  d_o;
  logic        hit_o;
  logic [15:0] pad_i = 16'h003C;
  logic [15:0] port_o;
  logic [15:0] port_oe;
  logic        irq_n_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  io_port_bank #(
    .NPORTS     (2),
    .WIDTH      (8),
    .BASE       (Base),
    .PORT_RST   (PortRst),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i  (clk_i),
    .rst_n  (rst_n),
    .a_i    (a_i),
    .d_i    (d_i),
    .rwn_i  (rwn_i),
    .acc_i  (acc_i),
    .d_o    (d_o),
    .hit_o  (hit_o),
    .pad_i  (pad_i),
    .port_o (port_o),
    .port_oe(port_oe),
    .irq_n_o(irq_n_o)
  );

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp;
    bit          hit;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Starts and ends at a falling edge; the write commits on the rising edge between.
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk_i);
    a_i = a; d_i = d; rwn_i = 1'b0; acc_i = 1'b1;
    @(negedge clk_i);
    acc_i = 1'b0; rwn_i = 1'b1;
  endtask

  // Combinational read, sampled mid low phase.
  task automatic rd(input string name, input logic [15:0] a, input logic [7:0] exp,
                    input logic exp_hit);
    a_i = a; rwn_i = 1'b1; acc_i = 1'b1;
    #1;
    check(name, d_o, exp);
    check({name, " hit"}, hit_o, exp_hit);
    acc_i = 1'b0;
  endtask

  function automatic vec_t v(input bit w, input logic [15:0] a, input logic [7:0] d,
                             input logic [7:0] e, input bit h);
    vec_t r;
    r.wr = w; r.addr = a; r.data = d; r.exp = e; r.hit = h;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state (pad port0 = 3C, port1 = 00), settled synchronizer.
    vecs.push_back(v(0, 16'h0020, 8'h00, 8'h00, 1));
    vecs.push_back(v(0, 16'h0021, 8'h00, 8'h81, 1));
    vecs.push_back(v(0, 16'h0022, 8'h00, 8'h3C, 1));
    vecs.push_back(v(0, 16'h0023, 8'h00, 8'h00, 1));
    vecs.push_back(v(0, 16'h0024, 8'h00, 8'h00, 1));
    vecs.push_back(v(0, 16'h0025, 8'h00, 8'h00, 1));
    vecs.push_back(v(0, 16'h0028, 8'h00, 8'h00, 1));
    vecs.push_back(v(0, 16'h0029, 8'h00, 8'h81, 1));
    vecs.push_back(v(0, 16'h002A, 8'h00, 8'h00, 1));
    vecs.push_back(v(0, 16'h002C, 8'h00, 8'h00, 1));
    // DDR/PORT/PIN/toggle on port 0.
    vecs.push_back(v(1, 16'h0020, 8'hF0, 8'h00, 1));
    vecs.push_back(v(1, 16'h0021, 8'hA5, 8'h00, 1));
    vecs.push_back(v(0, 16'h0020, 8'h00, 8'hF0, 1));
    vecs.push_back(v(0, 16'h0021, 8'h00, 8'hA5, 1));
    vecs.push_back(v(0, 16'h0022, 8'h00, 8'hAC, 1));
    vecs.push_back(v(1, 16'h0022, 8'h0F, 8'h00, 1));
    vecs.push_back(v(0, 16'h0021, 8'h00, 8'hAA, 1));
    vecs.push_back(v(0, 16'h0022, 8'h00, 8'hAC, 1));
    // Reserved registers and out-of-range decode.
    vecs.push_back(v(1, 16'h0026, 8'hFF, 8'h00, 1));
    vecs.push_back(v(1, 16'h0027, 8'hFF, 8'h00, 1));
    vecs.push_back(v(0, 16'h0026, 8'h00, 8'h00, 1));
    vecs.push_back(v(0, 16'h0027, 8'h00, 8'h00, 1));
    vecs.push_back(v(0, 16'h0030, 8'h00, 8'h00, 0));
    vecs.push_back(v(0, 16'h0040, 8'h00, 8'h00, 0));
    vecs.push_back(v(0, 16'h0008, 8'h00, 8'h00, 0));
    vecs.push_back(v(1, 16'h0040, 8'hFF, 8'h00, 0));
    vecs.push_back(v(1, 16'h0008, 8'hFF, 8'h00, 0));
    vecs.push_back(v(0, 16'h0020, 8'h00, 8'hF0, 1));
    vecs.push_back(v(0, 16'h0021, 8'h00, 8'hAA, 1));
    vecs.push_back(v(0, 16'h0028, 8'h00, 8'h00, 1));
    // Port 1.
    vecs.push_back(v(1, 16'h0028, 8'h0F, 8'h00, 1));
    vecs.push_back(v(1, 16'h0029, 8'h3C, 8'h00, 1));
    vecs.push_back(v(0, 16'h002A, 8'h00, 8'h0C, 1));
    vecs.push_back(v(1, 16'h002A, 8'hFF, 8'h00, 1));
    vecs.push_back(v(0, 16'h0029, 8'h00, 8'hC3, 1));
    vecs.push_back(v(0, 16'h002A, 8'h00, 8'h03, 1));
    // Interrupt registers (zero when the feature is absent).
    vecs.push_back(v(1, 16'h002B, 8'h55, 8'h00, 1));
    vecs.push_back(v(0, 16'h002B, 8'h00, IrqEn ? 8'h55 : 8'h00, 1));
    vecs.push_back(v(1, 16'h0025, 8'hFF, 8'h00, 1));
    vecs.push_back(v(0, 16'h0025, 8'h00, IrqEn ? 8'hFF : 8'h00, 1));
    vecs.push_back(v(1, 16'h0025, 8'h00, 8'h00, 1));
    vecs.push_back(v(1, 16'h002D, 8'h01, 8'h00, 1));
    vecs.push_back(v(0, 16'h002D, 8'h00, IrqEn ? 8'h01 : 8'h00, 1));
    vecs.push_back(v(1, 16'h002B, 8'h01, 8'h00, 1));
    vecs.push_back(v(0, 16'h002B, 8'h00, IrqEn ? 8'h01 : 8'h00, 1));
    vecs.push_back(v(0, 16'h002C, 8'h00, 8'h00, 1));

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_n = 1'b1;
    repeat (6) @(posedge clk_i);
    @(negedge clk_i);
    check("reset irq_n", irq_n_o, 1'b1);
    check("reset port_oe", port_oe, 16'h0000);
    check("reset port_o", port_o, 16'h8181);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) begin
        wr(vecs[i].addr, vecs[i].data);
      end else begin
        @(negedge clk_i);
        rd($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp, vecs[i].hit);
      end
    end

    // Outputs follow a write one clock later.
    check("port_oe", port_oe, 16'h0FF0);
    @(negedge clk_i);
    a_i = 16'h0021; d_i = 8'h11; rwn_i = 1'b0; acc_i = 1'b1;
    #1 check("port_o before edge", port_o, 16'hC3AA);
    @(posedge clk_i);
    #1 check("port_o after edge", port_o, 16'hC311);
    @(negedge clk_i);
    acc_i = 1'b0; rwn_i = 1'b1;

    // Rising edge on port1 bit0 (EDGE=1, IER=1).
    @(negedge clk_i);
    pad_i = 16'h013C;
    a_i = 16'h002C; rwn_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("ifr set", d_o, IrqEn ? 8'h01 : 8'h00);
    check("irq still high", irq_n_o, 1'b1);
    @(posedge clk_i);
    #1 check("irq low", irq_n_o, IrqEn ? 1'b0 : 1'b1);
    wr(16'h002C, 8'h01);
    rd("ifr cleared", 16'h002C, 8'h00, 1);
    check("irq lag", irq_n_o, IrqEn ? 1'b0 : 1'b1);
    @(posedge clk_i);
    #1 check("irq released", irq_n_o, 1'b1);

    // Falling edge with EDGE=1 is ignored.
    @(negedge clk_i);
    pad_i = 16'h003C;
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    rd("no fall flag", 16'h002C, 8'h00, 1);

    // Falling edge on bit1 (EDGE=0) flags without IER, no interrupt.
    pad_i = 16'h023C;
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    pad_i = 16'h003C;
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    rd("fall flag", 16'h002C, IrqEn ? 8'h02 : 8'h00, 1);
    check("masked irq", irq_n_o, 1'b1);
    wr(16'h002C, 8'h02);

    // Set bit0, drop pad, then W1C coinciding with a new rising edge.
    pad_i = 16'h013C;
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    pad_i = 16'h003C;
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    pad_i = 16'h013C;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    a_i = 16'h002C; d_i = 8'h01; rwn_i = 1'b0; acc_i = 1'b1;
    @(negedge clk_i);
    acc_i = 1'b0; rwn_i = 1'b1;
    rd("set beats w1c", 16'h002C, IrqEn ? 8'h01 : 8'h00, 1);
    @(posedge clk_i);
    #1 check("irq after race", irq_n_o, IrqEn ? 1'b0 : 1'b1);
    wr(16'h002C, 8'h01);
    rd("w1c after race", 16'h002C, 8'h00, 1);

    // Reset with a concurrent write; pads held high through release.
    @(negedge clk_i);
    rst_n = 1'b0; pad_i = 16'hFFFF;
    a_i = 16'h0020; d_i = 8'h77; rwn_i = 1'b0; acc_i = 1'b1;
    @(negedge clk_i);
    acc_i = 1'b0; rwn_i = 1'b1;
    check("mid reset port_oe", port_oe, 16'h0000);
    check("mid reset port_o", port_o, 16'h8181);
    check("mid reset irq", irq_n_o, 1'b1);
    @(negedge clk_i);
    // EDGE set to rising before the synchronizer has filled.
    rst_n = 1'b1;
    a_i = 16'h002D; d_i = 8'hFF; rwn_i = 1'b0; acc_i = 1'b1;
    @(negedge clk_i);
    a_i = 16'h0025;
    @(negedge clk_i);
    acc_i = 1'b0; rwn_i = 1'b1;
    repeat (6) @(posedge clk_i);
    @(negedge clk_i);
    rd("reset write dropped", 16'h0020, 8'h00, 1);
    rd("edge1 written", 16'h002D, IrqEn ? 8'hFF : 8'h00, 1);
    rd("no arm flag p0", 16'h0024, 8'h00, 1);
    rd("no arm flag p1", 16'h002C, 8'h00, 1);
    check("no arm irq", irq_n_o, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
